// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative mul/div unit owning the HI/LO register pair.
// Runs one shift-add or restoring-divide step per cycle; MTHI/MTLO in one.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   Start, Op, A, B   launch request, opcode and operands (used when idle)
//   Busy              high while an operation is in flight
//   Done, DivByZero   one-cycle retirement / divide-by-zero pulses
//   Hi, Lo            architectural HI/LO registers
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int W  = WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          is_mul;
  logic          is_div;
  logic          is_mthi;
  logic          is_mtlo;
  logic          signed_op;
  logic          b_zero;
  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  a_abs;
  logic [W-1:0]  b_abs;

  logic [2:0]    op_q;
  logic          neg_p;
  logic          neg_r;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [2*W-1:0] prod;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [CW-1:0] cnt;

  logic [W:0]     sum;
  logic [2*W-1:0] prod_step;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   rem_step;
  logic [W-1:0]   quo_step;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] res_hl;

  // Launch decode
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (1'b1)
      (Op[2] == 1'b0):    is_mul  = 1'b1;
      (Op[2:1] == 2'b10): is_div  = 1'b1;
      (Op == OP_MTHI):    is_mthi = 1'b1;
      (Op == OP_MTLO):    is_mtlo = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    signed_op = (Op != OP_MULTU) && (Op != OP_DIVU);
    b_zero    = (B == '0);
    a_neg     = signed_op & A[W-1];
    b_neg     = signed_op & B[W-1];
    a_abs     = a_neg ? -A : A;
    b_abs     = b_neg ? -B : B;
  end

  // One shift-add step: add multiplicand into the upper half, shift right
  always_comb begin
    sum       = {1'b0, prod[2*W-1:W]}
              + (prod[0] ? {1'b0, a_mag} : '0);
    prod_step = {sum, prod[W-1:1]};
  end

  // One restoring-divide step
  always_comb begin
    shifted  = {rem, quo[W-1]};
    ge       = (shifted >= {1'b0, b_mag});
    rem_step = ge ? W'(shifted - {1'b0, b_mag})
                  : shifted[W-1:0];
    quo_step = {quo[W-2:0], ge};
  end

  // Sign fix-up and accumulate at retirement; negating the magnitude of
  // most-negative / -1 wraps back to most-negative as intended
  always_comb begin
    prod_s = neg_p ? -prod : prod;
    unique case (op_q)
      OP_MULT,
      OP_MULTU: res_hl = prod_s;
      OP_MADD:  res_hl = {Hi, Lo} + prod_s;
      OP_MSUB:  res_hl = {Hi, Lo} - prod_s;
      OP_DIV,
      OP_DIVU:  res_hl = {neg_r ? -rem : rem,
                          neg_p ? -quo : quo};
      default:  res_hl = {Hi, Lo};
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (Start && is_mul)
          state_nxt = S_MUL;
        else if (Start && is_div && !b_zero)
          state_nxt = S_DIV;
      end
      S_MUL:   if (cnt == LAST) state_nxt = S_FIN;
      S_DIV:   if (cnt == LAST) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy = (state != S_IDLE);
  end

  // Datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi        <= '0;
      Lo        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      op_q      <= '0;
      neg_p     <= 1'b0;
      neg_r     <= 1'b0;
      a_mag     <= '0;
      b_mag     <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            op_q  <= Op;
            neg_p <= a_neg ^ b_neg;
            neg_r <= a_neg;
            a_mag <= a_abs;
            b_mag <= b_abs;
            prod  <= {{W{1'b0}}, b_abs};
            rem   <= '0;
            quo   <= a_abs;
            cnt   <= '0;
            unique case (1'b1)
              is_mthi: begin
                Hi   <= A;
                Done <= 1'b1;
              end
              is_mtlo: begin
                Lo   <= A;
                Done <= 1'b1;
              end
              (is_div && b_zero): begin
                Done      <= 1'b1;
                DivByZero <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          prod <= prod_step;
          cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        S_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
        S_FIN: begin
          {Hi, Lo} <= res_hl;
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed bench for hilo_muldiv_unit (WIDTH=32).
// Arithmetic reference model compared every cycle, plus literal pins.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .A(A),
    .B(B),
    .Busy(Busy),
    .Done(Done),
    .DivByZero(DivByZero),
    .Hi(Hi),
    .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic on whole 64-bit values
  function automatic logic [63:0] model_result(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] hl
  );
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'b000: return 64'(sa * sb);
      3'b001: return ua * ub;
      3'b010: return hl + 64'(sa * sb);
      3'b011: return hl - 64'(sa * sb);
      3'b100: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'b101: begin
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
      default: return hl;
    endcase
  endfunction

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_done = 1'b0;
  logic        m_dbz = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res = '0;

  // Model: a launched mul/div keeps the unit busy W+1 cycles, then retires
  always @(posedge Clk) begin
    if (Reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_res;
          m_done <= 1'b1;
        end
      end else if (Start) begin
        case (Op)
          3'b110: begin
            m_hi   <= A;
            m_done <= 1'b1;
          end
          3'b111: begin
            m_lo   <= A;
            m_done <= 1'b1;
          end
          default: begin
            if (Op[2] && B == 32'h0) begin
              m_done <= 1'b1;
              m_dbz  <= 1'b1;
            end else begin
              m_res  <= model_result(Op, A, B, {m_hi, m_lo});
              m_left <= W + 1;
            end
          end
        endcase
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("busy", 64'(Busy), 64'(m_left != 0));
      check("done", 64'(Done), 64'(m_done));
      check("dbz", 64'(DivByZero), 64'(m_dbz));
      check("hi", 64'(Hi), 64'(m_hi));
      check("lo", 64'(Lo), 64'(m_lo));
    end
  end

  always @(negedge Clk) begin
    if (Done === 1'b1) done_cnt++;
  end

  // Drive a one-cycle Start, then scramble inputs to prove operand latching
  task automatic launch(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    Op    = ~op;
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (Done !== 1'b1 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
    end
    if (Done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout got no Done want Done by cycle 60");
    end
  endtask

  task automatic run(input string name,
                     input bit b2b,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int ecyc,
                     input logic [31:0] ehi,
                     input logic [31:0] elo,
                     input logic edbz);
    int cyc;
    if (!b2b) @(negedge Clk);
    launch(op, a, b);
    wait_done(1, cyc);
    check({name, "_cyc"}, 64'(cyc), 64'(ecyc));
    check({name, "_hi"}, 64'(Hi), 64'(ehi));
    check({name, "_lo"}, 64'(Lo), 64'(elo));
    check({name, "_dbz"}, 64'(DivByZero), 64'(edbz));
  endtask

  initial begin
    int cyc;
    int dc0;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = '0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_en = 1'b1;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    Reset = 1'b0;

    run("mult", 0, 3'b000, 32'hFFFFFFFF, 32'h2,
        34, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run("multu_b2b", 1, 3'b001, 32'hFFFFFFFF, 32'h2,
        34, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run("mthi", 0, 3'b110, 32'h0, 32'h9,
        1, 32'h0, 32'hFFFFFFFE, 1'b0);
    run("mtlo", 0, 3'b111, 32'h5, 32'h9,
        1, 32'h0, 32'h5, 1'b0);
    run("madd", 0, 3'b010, 32'h3, 32'h4,
        34, 32'h0, 32'h11, 1'b0);
    run("msub", 0, 3'b011, 32'h3, 32'h7,
        34, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0);
    run("div_neg", 0, 3'b100, 32'hFFFFFFF9, 32'h2,
        34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_ovf", 0, 3'b100, 32'h80000000, 32'hFFFFFFFF,
        34, 32'h0, 32'h80000000, 1'b0);
    run("div_negb", 0, 3'b100, 32'h7, 32'hFFFFFFFE,
        34, 32'h1, 32'hFFFFFFFD, 1'b0);
    run("divu", 0, 3'b101, 32'd100, 32'd7,
        34, 32'h2, 32'hE, 1'b0);
    run("divu_max", 0, 3'b101, 32'hFFFFFFFF, 32'h1,
        34, 32'h0, 32'hFFFFFFFF, 1'b0);
    run("mult_minmin", 0, 3'b000, 32'h80000000, 32'h80000000,
        34, 32'h40000000, 32'h0, 1'b0);
    run("multu_max", 0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF,
        34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mthi_aa", 0, 3'b110, 32'hAA, 32'h0,
        1, 32'hAA, 32'h00000001, 1'b0);
    run("mtlo_bb", 0, 3'b111, 32'hBB, 32'h0,
        1, 32'hAA, 32'hBB, 1'b0);
    run("divu_zero", 0, 3'b101, 32'h1234, 32'h0,
        1, 32'hAA, 32'hBB, 1'b1);
    run("div_zero", 0, 3'b100, 32'h0, 32'h0,
        1, 32'hAA, 32'hBB, 1'b1);

    // Start while busy is dropped: only one Done, Hi not overwritten
    @(negedge Clk);
    launch(3'b001, 32'd6, 32'd7);
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    Op    = 3'b110;
    A     = 32'hDEAD;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(6, cyc);
    check("ign_cyc", 64'(cyc), 64'd34);
    check("ign_hi", 64'(Hi), 64'd0);
    check("ign_lo", 64'(Lo), 64'h2A);
    @(negedge Clk);
    dc0 = done_cnt;
    repeat (40) @(negedge Clk);
    check("ign_done_cnt", 64'(done_cnt), 64'(dc0));

    // Reset in cycle 10 of a MULT with a stray Start at cycle 3
    @(negedge Clk);
    launch(3'b000, 32'd5, 32'd5);
    repeat (2) @(negedge Clk);
    Start = 1'b1;
    Op    = 3'b111;
    A     = 32'h77;
    @(negedge Clk);
    Start = 1'b0;
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_busy", 64'(Busy), 64'd0);
    check("mid_rst_done", 64'(Done), 64'd0);
    check("mid_rst_hi", 64'(Hi), 64'd0);
    check("mid_rst_lo", 64'(Lo), 64'd0);
    Reset = 1'b0;
    dc0 = done_cnt;
    repeat (40) @(negedge Clk);
    check("mid_rst_no_done", 64'(done_cnt), 64'(dc0));

    run("post_rst_mult", 0, 3'b000, 32'hFFFFFFFD, 32'h5,
        34, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
